// File: rtl/branch_predictor_if.sv
// Bundles the fetch-side prediction port, the EX-side resolution port and the
// statistics outputs of the branch direction predictor.
// master = pipeline side, slave = predictor side.
interface branch_predictor_if #(
  parameter int unsigned STAT_WIDTH = 32
);
  // fetch side
  logic [63:0]           if_pc;
  logic                  if_valid;
  logic                  predict_taken;

  // pipeline control
  logic                  stall;
  logic                  flush;

  // EX-side resolution
  logic [63:0]           ex_pc;
  logic                  ex_is_branch;
  logic                  ex_taken;
  logic                  mispredict;
  logic                  ex_pred;

  // statistics
  logic [STAT_WIDTH-1:0] branch_count;
  logic [STAT_WIDTH-1:0] mispredict_count;

  modport master (
    output if_pc, if_valid, stall, flush, ex_pc, ex_is_branch, ex_taken,
    input  predict_taken, mispredict, ex_pred, branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, if_valid, stall, flush, ex_pc, ex_is_branch, ex_taken,
    output predict_taken, mispredict, ex_pred, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: a table of 2-bit saturating counters
// indexed by pc[INDEX_BITS+1:2] predicts at IF; the prediction is carried
// through ID/EX and checked against the resolved direction in EX, where a
// disagreement raises a one-cycle mispredict and the counter is trained.
module branch_predictor #(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned STAT_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  logic [1:0]            table_q [ENTRIES];
  logic [1:0]            trained_ctr;
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;

  logic                  id_valid_q;
  logic                  id_pred_q;
  logic                  ex_valid_q;
  logic                  ex_pred_q;

  logic                  predict;
  logic                  resolve;
  logic                  mispredict;

  logic [STAT_WIDTH-1:0] branch_count_q;
  logic [STAT_WIDTH-1:0] mispredict_count_q;

  logic                  unused_pc_bits;

  // Table index extraction; the remaining PC bits do not select an entry.
  always_comb begin
    if_idx = bp.if_pc[INDEX_BITS+1:2];
    ex_idx = bp.ex_pc[INDEX_BITS+1:2];
  end

  assign unused_pc_bits = ^{bp.if_pc[63:INDEX_BITS+2], bp.if_pc[1:0],
                            bp.ex_pc[63:INDEX_BITS+2], bp.ex_pc[1:0]};

  // Combinational prediction (no bypass of a same-cycle update) and EX check.
  always_comb begin
    predict    = bp.if_valid & table_q[if_idx][1];
    resolve    = ex_valid_q & bp.ex_is_branch & ~bp.stall;
    mispredict = resolve & (ex_pred_q != bp.ex_taken);
  end

  // Saturating step of the counter addressed by the resolving branch.
  always_comb begin
    trained_ctr = table_q[ex_idx];
    if (bp.ex_taken) begin
      if (table_q[ex_idx] != STRONG_T) begin
        trained_ctr = table_q[ex_idx] + 2'd1;
      end
    end else begin
      if (table_q[ex_idx] != STRONG_NT) begin
        trained_ctr = table_q[ex_idx] - 2'd1;
      end
    end
  end

  // Counter table: reset to weak-NT, trained on every resolution.
  // Flush does not gate training; only stall does, through resolve.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        table_q[i] <= WEAK_NT;
      end
    end else if (resolve) begin
      table_q[ex_idx] <= trained_ctr;
    end
  end

  // ID/EX carry stages for {valid, pred}; killed by flush or mispredict.
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_pred_q  <= 1'b0;
    end else if (bp.flush || mispredict) begin
      id_valid_q <= 1'b0;
      id_pred_q  <= 1'b0;
      ex_valid_q <= 1'b0;
      ex_pred_q  <= 1'b0;
    end else if (!bp.stall) begin
      id_valid_q <= bp.if_valid;
      id_pred_q  <= predict;
      ex_valid_q <= id_valid_q;
      ex_pred_q  <= id_pred_q;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      if (resolve && (branch_count_q != '1)) begin
        branch_count_q <= branch_count_q + STAT_WIDTH'(1);
      end
      if (mispredict && (mispredict_count_q != '1)) begin
        mispredict_count_q <= mispredict_count_q + STAT_WIDTH'(1);
      end
    end
  end

  // Output drive.
  always_comb begin
    bp.predict_taken    = predict;
    bp.mispredict       = mispredict;
    bp.ex_pred          = ex_pred_q & ex_valid_q;
    bp.branch_count     = branch_count_q;
    bp.mispredict_count = mispredict_count_q;
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, randomized run against a
// behavioural model, and a saturation run on a 4-bit statistics build.
module tb_branch_predictor;

  logic clk;
  logic reset;

  branch_predictor_if #(.STAT_WIDTH(32)) bp ();
  branch_predictor_if #(.STAT_WIDTH(4))  bp4 ();

  branch_predictor #(.INDEX_BITS(4), .STAT_WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp)
  );

  branch_predictor #(.INDEX_BITS(4), .STAT_WIDTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bp    (bp4)
  );

  // the narrow build sees exactly the same stimulus
  assign bp4.if_pc        = bp.if_pc;
  assign bp4.if_valid     = bp.if_valid;
  assign bp4.stall        = bp.stall;
  assign bp4.flush        = bp.flush;
  assign bp4.ex_pc        = bp.ex_pc;
  assign bp4.ex_is_branch = bp.ex_is_branch;
  assign bp4.ex_taken     = bp.ex_taken;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint unsigned act,
                       input longint unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit r, input bit iv, input logic [63:0] ipc,
                       input bit st, input bit fl, input bit br, input bit tk,
                       input logic [63:0] epc);
    reset           = r;
    bp.if_valid     = iv;
    bp.if_pc        = ipc;
    bp.stall        = st;
    bp.flush        = fl;
    bp.ex_is_branch = br;
    bp.ex_taken     = tk;
    bp.ex_pc        = epc;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_n;
    bit          iv;
    logic [63:0] ipc;
    bit          st;
    bit          fl;
    bit          br;
    bit          tk;
    logic [63:0] epc;
    bit          e_pt;
    bit          e_mis;
    bit          e_xp;
    int          e_bc;
    int          e_mc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(bit r, bit iv, logic [63:0] ipc, bit st, bit fl,
                             bit br, bit tk, logic [63:0] epc, bit pt, bit mis,
                             bit xp, int bc, int mc);
    vec_t x;
    x.rst_n = r;  x.iv = iv;  x.ipc = ipc; x.st = st;  x.fl = fl;
    x.br = br;    x.tk = tk;  x.epc = epc; x.e_pt = pt; x.e_mis = mis;
    x.e_xp = xp;  x.e_bc = bc; x.e_mc = mc;
    return x;
  endfunction

  // ---------------- behavioural model ----------------
  int      m_ctr [16];     // 0..3, prediction = counter >= 2
  bit      m_valid [2];    // [0] = ID slot, [1] = EX slot
  bit      m_pred [2];
  longint  m_bc;           // unbounded counts; saturation applied on compare
  longint  m_mc;

  function automatic longint sat(longint c, int width);
    longint mx;
    mx = (longint'(1) << width) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_ctr[i] = 1;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_pred[i]  = 1'b0;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  // Compare current outputs with the model, then advance the model by one edge.
  task automatic step_model();
    int fi, ei;
    bit pt, res, mis;
    #1;
    fi  = int'((bp.if_pc / 4) % 16);
    ei  = int'((bp.ex_pc / 4) % 16);
    pt  = bp.if_valid && (m_ctr[fi] >= 2);
    res = m_valid[1] && bp.ex_is_branch && !bp.stall;
    mis = res && (m_pred[1] != bp.ex_taken);
    check("rnd.predict_taken", bp.predict_taken, pt);
    check("rnd.mispredict", bp.mispredict, mis);
    check("rnd.ex_pred", bp.ex_pred, m_valid[1] && m_pred[1]);
    check("rnd.branch_count", bp.branch_count, sat(m_bc, 32));
    check("rnd.mispredict_count", bp.mispredict_count, sat(m_mc, 32));
    check("rnd.branch_count_w4", bp4.branch_count, sat(m_bc, 4));
    check("rnd.mispredict_count_w4", bp4.mispredict_count, sat(m_mc, 4));
    if (!reset) begin
      model_reset();
    end else begin
      if (res) begin
        if (bp.ex_taken) m_ctr[ei] = (m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1;
        else             m_ctr[ei] = (m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1;
        m_bc++;
        if (mis) m_mc++;
      end
      if (bp.flush || mis) begin
        m_valid[0] = 1'b0; m_pred[0] = 1'b0;
        m_valid[1] = 1'b0; m_pred[1] = 1'b0;
      end else if (!bp.stall) begin
        m_valid[1] = m_valid[0]; m_pred[1] = m_pred[0];
        m_valid[0] = bp.if_valid; m_pred[0] = pt;
      end
    end
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] pc;
    int          guard;

    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);

    // reset; pc=0x40 taken twice; same-index read/update at index 3; flush
    // kill; stall hold; not-taken saturation at pc=0x80
    vecs.push_back(v(0,0,64'h00,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,1,64'h40,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,1,1,64'h40, 0,1,0,0,0));
    vecs.push_back(v(1,1,64'h40,0,0,0,0,64'h00, 1,0,0,1,1));
    vecs.push_back(v(1,0,64'h00,0,0,0,0,64'h00, 0,0,0,1,1));
    vecs.push_back(v(1,0,64'h00,0,0,1,1,64'h40, 0,0,1,1,1));
    vecs.push_back(v(1,1,64'h40,0,0,0,0,64'h00, 1,0,0,2,1));
    vecs.push_back(v(0,0,64'h00,0,0,0,0,64'h00, 0,0,0,2,1));
    vecs.push_back(v(1,1,64'h0C,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,1,64'h0C,0,0,1,1,64'h0C, 0,1,0,0,0));
    vecs.push_back(v(1,1,64'h0C,0,0,0,0,64'h00, 1,0,0,1,1));
    vecs.push_back(v(1,0,64'h00,0,1,0,0,64'h00, 0,0,0,1,1));
    vecs.push_back(v(1,0,64'h00,0,0,1,0,64'h0C, 0,0,0,1,1));
    vecs.push_back(v(1,1,64'h0C,0,0,1,0,64'h0C, 1,0,0,1,1));
    vecs.push_back(v(0,0,64'h00,0,0,0,0,64'h00, 0,0,0,1,1));
    vecs.push_back(v(1,1,64'h40,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,1,0,1,1,64'h40, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,1,0,1,1,64'h40, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,1,0,1,1,64'h40, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,1,1,64'h40, 0,1,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,1,1,64'h40, 0,0,0,1,1));
    vecs.push_back(v(1,0,64'h00,0,0,0,0,64'h00, 0,0,0,1,1));
    vecs.push_back(v(0,0,64'h00,0,0,0,0,64'h00, 0,0,0,1,1));
    vecs.push_back(v(1,1,64'h80,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,1,64'h80,0,0,0,0,64'h00, 0,0,0,0,0));
    vecs.push_back(v(1,1,64'h80,0,0,1,0,64'h80, 0,0,0,0,0));
    vecs.push_back(v(1,0,64'h00,0,0,1,0,64'h80, 0,0,0,1,0));
    vecs.push_back(v(1,0,64'h00,0,0,1,0,64'h80, 0,0,0,2,0));
    vecs.push_back(v(1,1,64'h80,0,0,0,0,64'h00, 0,0,0,3,0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].iv, vecs[i].ipc, vecs[i].st, vecs[i].fl,
            vecs[i].br, vecs[i].tk, vecs[i].epc);
      #1;
      check($sformatf("vec%0d.predict_taken", i), bp.predict_taken, vecs[i].e_pt);
      check($sformatf("vec%0d.mispredict", i), bp.mispredict, vecs[i].e_mis);
      check($sformatf("vec%0d.ex_pred", i), bp.ex_pred, vecs[i].e_xp);
      check($sformatf("vec%0d.branch_count", i), bp.branch_count, vecs[i].e_bc);
      check($sformatf("vec%0d.mispredict_count", i), bp.mispredict_count, vecs[i].e_mc);
      check($sformatf("vec%0d.branch_count_w4", i), bp4.branch_count, vecs[i].e_bc);
    end

    // randomized run against the model
    reset_cycle();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      pc = {$urandom(), $urandom()};
      pc[5:2] = 4'($urandom_range(0, 3));
      bp.if_pc    = pc;
      bp.if_valid = ($urandom_range(0, 99) < 70);
      pc = {$urandom(), $urandom()};
      pc[5:2] = 4'($urandom_range(0, 3));
      bp.ex_pc        = pc;
      bp.ex_is_branch = ($urandom_range(0, 99) < 60);
      bp.ex_taken     = ($urandom_range(0, 99) < 50);
      bp.stall        = ($urandom_range(0, 99) < 25);
      bp.flush        = ($urandom_range(0, 99) < 10);
      reset           = !($urandom_range(0, 99) < 3);
      step_model();
    end

    // statistics saturation: keep resolving every branch opposite to its prediction
    reset_cycle();
    guard = 0;
    while (m_mc < 20 && guard < 200) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 1'b1, !m_pred[1], 64'h100);
      step_model();
      guard++;
    end
    check("sat.loop_bound", guard < 200, 1);
    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    check("sat.branch_count_w4", bp4.branch_count, 15);
    check("sat.mispredict_count_w4", bp4.mispredict_count, 15);
    check("sat.branch_count_w32", bp.branch_count, 20);
    check("sat.mispredict_count_w32", bp.mispredict_count, 20);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 64'h100, 1'b0, 1'b0, 1'b1, !m_pred[1], 64'h100);
      step_model();
    end
    @(negedge clk);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    check("sat.held_branch_count_w4", bp4.branch_count, 15);
    check("sat.held_mispredict_count_w4", bp4.mispredict_count, 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch direction predictor for the five-stage RISC-V pipeline. It predicts taken/not-taken at fetch from a table of 2-bit saturating counters indexed by PC. It carries each prediction down to EX and compares it there against the branch-taken select produced by the branching unit. On a mismatch it raises a one-cycle mispredict/flush, then trains the counter and updates statistics counters.

## Interface
- INDEX_BITS, 4, log2 of counter-table entries (16 entries); index = pc[INDEX_BITS+1:2]
- STAT_WIDTH, 32, width of the branch and mispredict statistics counters
- clk  input  1  rising-edge clock; only clock in the block
- reset  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
- if_pc  input  64  PC of the instruction in IF
- if_valid  input  1  IF holds a real instruction
- predict_taken  output  1  combinational prediction for if_pc, equal to counter[idx(if_pc)][1]; 0 when if_valid=0
- stall  input  1  pipeline stall; holds internal stage registers and blocks training
- flush  input  1  external flush (jumps, exceptions); kills in-flight predictions
- ex_pc  input  64  PC of the instruction in EX
- ex_is_branch  input  1  EX instruction is a conditional branch (funct3 000/100/101)
- ex_taken  input  1  resolved direction from the branching unit (its mux select)
- mispredict  output  1  EX branch resolved opposite to its carried prediction
- ex_pred  output  1  prediction carried to EX (debug/visibility)
- branch_count  output  STAT_WIDTH  resolved branches since reset, saturating
- mispredict_count  output  STAT_WIDTH  mispredictions since reset, saturating

## Operation
- Table: 2^INDEX_BITS counters, 2 bits each. Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. Reset value: every entry 01.
- Prediction path: predict_taken = if_valid & table[if_pc[INDEX_BITS+1:2]][1]. Read is combinational. There is no bypass: a same-cycle update to the same index is not visible until the next cycle.
- Carry pipeline: two stages (ID, EX), each holding {valid, pred}.
  - Rising edge with reset=0: both stages cleared.
  - Else if flush=1 or mispredict=1: both stages cleared.
  - Else if stall=1: both stages hold.
  - Else: ID <= {if_valid, predict_taken}; EX <= ID.
- ex_pred = EX.pred & EX.valid.
- Resolution: resolve = EX.valid & ex_is_branch & ~stall.
  - mispredict = resolve & (EX.pred != ex_taken). Combinational, so it is asserted in the same cycle as the resolution.
- Training happens on the edge ending a cycle where resolve=1, at index ex_pc[INDEX_BITS+1:2].
  - ex_taken=1: counter increments, saturating at 11.
  - ex_taken=0: counter decrements, saturating at 00.
- Training is independent of flush. A resolution in the same cycle as flush=1 still trains and still counts.
- Statistics:
  - branch_count increments by 1 on each edge with resolve=1.
  - mispredict_count increments by 1 on each edge with mispredict=1.
  - Both saturate at all-ones and never wrap.
- Non-branch EX instructions (ex_is_branch=0) never train, count, or mispredict.

## Timing
- Prediction latency is 0 cycles (combinational from if_pc).
- The prediction reaches EX two unstalled edges after fetch.
- mispredict is valid in the EX cycle. Its flush effect on the carry stages takes hold on the following edge.
- Reset behaviour:
  - Output reset values: predict_taken=0 (if_valid is low during reset), mispredict=0, ex_pred=0, counts=0.
  - Reset mid-operation discards in-flight predictions and restores every counter to 01 on the same edge.
- Simultaneous events:
  - stall=1 together with a valid EX branch: no mispredict, no training. The resolution occurs in the first unstalled cycle, exactly once.
  - flush=1 together with mispredict=1: both clear the stages on the same edge, so the effect is identical to either alone.
  - Same index read and trained in one cycle: the read returns the pre-update value.
  - Index aliasing between different PCs sharing pc[5:2] is permitted; those PCs share one counter.

## Test plan
- Reset, then a valid branch at pc=0x40 resolving taken twice:
  - First resolution: predict_taken=0, mispredict=1, counter 01->10.
  - Second fetch predicts 1; its resolution gives mispredict=0 and counter 10->11.
  - Final counts: branch_count=2, mispredict_count=1.
- Saturation: resolve pc=0x80 not-taken 3 times from reset. Counter goes 01->00->00. Prediction remains 0 and mispredict stays 0 on every resolution.
- Stall hold: EX holds a branch with pred=0 and ex_taken=1, stall=1 for 3 cycles, then 0. mispredict is 0 during the stall and 1 for exactly one cycle after it; branch_count increments by 1.
- Flush kill: predict taken at IF, assert flush next cycle. EX.valid never becomes 1 for that instruction, with no training and no count change.
- Same-index read/update: the cycle that trains index 3 from 01 to 10 also fetches pc=0x0C. That fetch predicts 0; a fetch of pc=0x0C in the next cycle predicts 1.
- Counter saturation (STAT_WIDTH=4 build): 20 resolved mispredicting branches give branch_count=15 and mispredict_count=15, held at 15.
